// File: rtl/ahbl_arbiter_if.sv
// ahbl_arbiter_if
//   Bus bundle for one ahbl_arbiter instance: N_PORTS upstream AHB-lite
//   ports (ahbls_*) and the single shared downstream port (ahblm_*).
//   Upstream per-port fields are packed arrays indexed by port number.
//   modport slave  : arbiter view (slave to the upstream masters, master
//                    to the downstream slave).
//   modport master : environment view (upstream masters plus downstream
//                    slave), the mirror of slave.
interface ahbl_arbiter_if #(
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned W_ADDR  = 32,
  parameter int unsigned W_DATA  = 32
);
  // Upstream ports
  logic [N_PORTS-1:0]             ahbls_hready;
  logic [N_PORTS-1:0]             ahbls_hready_resp;
  logic [N_PORTS-1:0]             ahbls_hresp;
  logic [N_PORTS-1:0][W_ADDR-1:0] ahbls_haddr;
  logic [N_PORTS-1:0]             ahbls_hwrite;
  logic [N_PORTS-1:0][1:0]        ahbls_htrans;
  logic [N_PORTS-1:0][2:0]        ahbls_hsize;
  logic [N_PORTS-1:0][2:0]        ahbls_hburst;
  logic [N_PORTS-1:0][3:0]        ahbls_hprot;
  logic [N_PORTS-1:0]             ahbls_hmastlock;
  logic [N_PORTS-1:0][W_DATA-1:0] ahbls_hwdata;
  logic [N_PORTS-1:0][W_DATA-1:0] ahbls_hrdata;

  // Downstream port
  logic              ahblm_hready;
  logic              ahblm_hready_resp;
  logic              ahblm_hresp;
  logic [W_ADDR-1:0] ahblm_haddr;
  logic              ahblm_hwrite;
  logic [1:0]        ahblm_htrans;
  logic [2:0]        ahblm_hsize;
  logic [2:0]        ahblm_hburst;
  logic [3:0]        ahblm_hprot;
  logic              ahblm_hmastlock;
  logic [W_DATA-1:0] ahblm_hwdata;
  logic [W_DATA-1:0] ahblm_hrdata;

  modport slave (
    input  ahbls_hready, ahbls_haddr, ahbls_hwrite, ahbls_htrans,
           ahbls_hsize, ahbls_hburst, ahbls_hprot, ahbls_hmastlock,
           ahbls_hwdata,
    output ahbls_hready_resp, ahbls_hresp, ahbls_hrdata,
    output ahblm_hready, ahblm_haddr, ahblm_hwrite, ahblm_htrans,
           ahblm_hsize, ahblm_hburst, ahblm_hprot, ahblm_hmastlock,
           ahblm_hwdata,
    input  ahblm_hready_resp, ahblm_hresp, ahblm_hrdata
  );

  modport master (
    output ahbls_hready, ahbls_haddr, ahbls_hwrite, ahbls_htrans,
           ahbls_hsize, ahbls_hburst, ahbls_hprot, ahbls_hmastlock,
           ahbls_hwdata,
    input  ahbls_hready_resp, ahbls_hresp, ahbls_hrdata,
    input  ahblm_hready, ahblm_haddr, ahblm_hwrite, ahblm_htrans,
           ahblm_hsize, ahblm_hburst, ahblm_hprot, ahblm_hmastlock,
           ahblm_hwdata,
    output ahblm_hready_resp, ahblm_hresp, ahblm_hrdata
  );
endinterface

// File: rtl/ahbl_arbiter.sv
// ahbl_arbiter
//   N:1 AHB-lite fixed-priority arbiter (port 0 highest). Requests that lose
//   arbitration or arrive during a downstream stall are held in a one-deep
//   per-port address buffer, so no upstream transfer is ever dropped.
//   Bursts are flattened into NONSEQ/SINGLE transfers downstream.
//   Ports:
//     clk   : clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : ahbl_arbiter_if.slave (upstream ahbls_* / downstream ahblm_*)
module ahbl_arbiter #(
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned W_ADDR  = 32,
  parameter int unsigned W_DATA  = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  ahbl_arbiter_if.slave  bus
);

  localparam int unsigned W_IDX = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic                           w_hready;
  logic [N_PORTS-1:0]             w_live;
  logic [N_PORTS-1:0]             w_req;
  logic [N_PORTS-1:0]             w_fresh;
  logic [N_PORTS-1:0]             w_gnt_a;
  logic                           w_found;
  logic [W_IDX-1:0]               w_sel_a;
  logic [W_IDX-1:0]               w_sel_d;
  logic                           w_unused;

  logic                           r_stalled;
  logic [N_PORTS-1:0]             r_gnt_hold;
  logic [N_PORTS-1:0]             r_gnt_d;
  logic [N_PORTS-1:0]             r_buf_valid;
  logic [N_PORTS-1:0][W_ADDR-1:0] r_buf_haddr;
  logic [N_PORTS-1:0]             r_buf_hwrite;
  logic [N_PORTS-1:0][2:0]        r_buf_hsize;
  logic [N_PORTS-1:0][3:0]        r_buf_hprot;
  logic [N_PORTS-1:0]             r_buf_hmastlock;

  assign w_hready         = bus.ahblm_hready_resp;
  assign bus.ahblm_hready = w_hready;

  // Upstream burst type and the SEQ/NONSEQ distinction are never forwarded.
  assign w_unused = ^{bus.ahbls_hburst, bus.ahbls_htrans};

  // Arbitration: fresh lowest-index decision, replaced by the held grant
  // while the previous cycle ended in a wait state.
  always_comb begin
    w_live  = '0;
    w_fresh = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      w_live[i] = bus.ahbls_htrans[i][1] & bus.ahbls_hready[i];
    end
    w_req = r_buf_valid | w_live;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      w_fresh[i] = w_req[i] & ~w_found;
      w_found    = w_found | w_req[i];
    end
    w_gnt_a = r_stalled ? r_gnt_hold : w_fresh;

    w_sel_a = '0;
    w_sel_d = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (w_gnt_a[i]) w_sel_a = W_IDX'(i);
      if (r_gnt_d[i]) w_sel_d = W_IDX'(i);
    end
  end

  // Downstream address and data phase
  always_comb begin
    bus.ahblm_htrans    = 2'b00;
    bus.ahblm_hburst    = 3'b000;
    bus.ahblm_haddr     = '0;
    bus.ahblm_hwrite    = 1'b0;
    bus.ahblm_hsize     = '0;
    bus.ahblm_hprot     = '0;
    bus.ahblm_hmastlock = 1'b0;
    if (|w_gnt_a) begin
      bus.ahblm_htrans = 2'b10;
      if (r_buf_valid[w_sel_a]) begin
        bus.ahblm_haddr     = r_buf_haddr[w_sel_a];
        bus.ahblm_hwrite    = r_buf_hwrite[w_sel_a];
        bus.ahblm_hsize     = r_buf_hsize[w_sel_a];
        bus.ahblm_hprot     = r_buf_hprot[w_sel_a];
        bus.ahblm_hmastlock = r_buf_hmastlock[w_sel_a];
      end else begin
        bus.ahblm_haddr     = bus.ahbls_haddr[w_sel_a];
        bus.ahblm_hwrite    = bus.ahbls_hwrite[w_sel_a];
        bus.ahblm_hsize     = bus.ahbls_hsize[w_sel_a];
        bus.ahblm_hprot     = bus.ahbls_hprot[w_sel_a];
        bus.ahblm_hmastlock = bus.ahbls_hmastlock[w_sel_a];
      end
    end
    bus.ahblm_hwdata = (|r_gnt_d) ? bus.ahbls_hwdata[w_sel_d] : '0;
  end

  // Upstream responses: data-phase owner sees the slave, a buffered port is
  // stalled, everyone else sees an idle-ready bus.
  always_comb begin
    bus.ahbls_hready_resp = '1;
    bus.ahbls_hresp       = '0;
    bus.ahbls_hrdata      = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      bus.ahbls_hrdata[i] = bus.ahblm_hrdata;
      if (r_gnt_d[i]) begin
        bus.ahbls_hready_resp[i] = bus.ahblm_hready_resp;
        bus.ahbls_hresp[i]       = bus.ahblm_hresp;
      end else if (r_buf_valid[i]) begin
        bus.ahbls_hready_resp[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stalled       <= 1'b0;
      r_gnt_hold      <= '0;
      r_gnt_d         <= '0;
      r_buf_valid     <= '0;
      r_buf_haddr     <= '0;
      r_buf_hwrite    <= '0;
      r_buf_hsize     <= '0;
      r_buf_hprot     <= '0;
      r_buf_hmastlock <= '0;
    end else begin
      r_stalled  <= ~w_hready;
      r_gnt_hold <= w_gnt_a;
      if (w_hready) r_gnt_d <= w_gnt_a;
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        if (w_live[i] && !(w_gnt_a[i] && w_hready)) begin
          r_buf_valid[i]     <= 1'b1;
          r_buf_haddr[i]     <= bus.ahbls_haddr[i];
          r_buf_hwrite[i]    <= bus.ahbls_hwrite[i];
          r_buf_hsize[i]     <= bus.ahbls_hsize[i];
          r_buf_hprot[i]     <= bus.ahbls_hprot[i];
          r_buf_hmastlock[i] <= bus.ahbls_hmastlock[i];
        end else if (w_gnt_a[i] && w_hready) begin
          r_buf_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahbl_arbiter.sv
// tb_ahbl_arbiter
//   Directed bench for ahbl_arbiter with two upstream ports. Each upstream
//   port's HREADY is looped back from its HREADYOUT, as it would be with a
//   single slave behind the port.
module tb_ahbl_arbiter;

  localparam int unsigned NP = 2;
  localparam int unsigned WA = 32;
  localparam int unsigned WD = 32;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  ahbl_arbiter_if #(.N_PORTS(NP), .W_ADDR(WA), .W_DATA(WD)) bus ();

  ahbl_arbiter #(.N_PORTS(NP), .W_ADDR(WA), .W_DATA(WD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.ahbls_hready = bus.ahbls_hready_resp;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic [1:0] tr, input logic [31:0] a,
                       input logic wr, input logic [2:0] burst);
    bus.ahbls_htrans[p]    = tr;
    bus.ahbls_haddr[p]     = a;
    bus.ahbls_hwrite[p]    = wr;
    bus.ahbls_hburst[p]    = burst;
    bus.ahbls_hsize[p]     = 3'b010;
    bus.ahbls_hprot[p]     = 4'b0011;
    bus.ahbls_hmastlock[p] = 1'b0;
  endtask

  task automatic idle(input int p);
    drive(p, 2'b00, 32'h0, 1'b0, 3'b000);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    idle(0);
    idle(1);
    bus.ahbls_hwdata      = '0;
    bus.ahblm_hready_resp = 1'b1;
    bus.ahblm_hresp       = 1'b0;
    bus.ahblm_hrdata      = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_htrans",   bus.ahblm_htrans, 2'b00);
    chk("rst_haddr",    bus.ahblm_haddr, 32'h0);
    chk("rst_hwdata",   bus.ahblm_hwdata, 32'h0);
    chk("rst_hreadyo",  bus.ahbls_hready_resp, 2'b11);
    chk("rst_hresp",    bus.ahbls_hresp, 2'b00);
    nxt();
    rst_n = 1'b1;

    // Uncontended write
    nxt();
    drive(0, 2'b10, 32'h100, 1'b1, 3'b000);
    #2;
    chk("w_htrans",  bus.ahblm_htrans, 2'b10);
    chk("w_haddr",   bus.ahblm_haddr, 32'h100);
    chk("w_hwrite",  bus.ahblm_hwrite, 1'b1);
    chk("w_hsize",   bus.ahblm_hsize, 3'b010);
    chk("w_hprot",   bus.ahblm_hprot, 4'b0011);
    chk("w_hlock",   bus.ahblm_hmastlock, 1'b0);
    chk("w_rdy0_a",  bus.ahbls_hready_resp[0], 1'b1);
    nxt();
    idle(0);
    bus.ahbls_hwdata[0] = 32'hDEADBEEF;
    #2;
    chk("w_hwdata",  bus.ahblm_hwdata, 32'hDEADBEEF);
    chk("w_rdy0_d",  bus.ahbls_hready_resp[0], 1'b1);
    chk("w_idle",    bus.ahblm_htrans, 2'b00);
    chk("w_mready",  bus.ahblm_hready, 1'b1);

    // Simultaneous reads
    nxt();
    bus.ahbls_hwdata[0] = 32'h0;
    drive(0, 2'b10, 32'h0, 1'b0, 3'b000);
    drive(1, 2'b10, 32'h4, 1'b0, 3'b000);
    #2;
    chk("sr_haddr_t",  bus.ahblm_haddr, 32'h0);
    chk("sr_htrans_t", bus.ahblm_htrans, 2'b10);
    chk("sr_rdy_t",    bus.ahbls_hready_resp, 2'b11);
    nxt();
    idle(0);
    idle(1);
    bus.ahblm_hrdata = 32'hAAAA0000;
    #2;
    chk("sr_haddr_t1", bus.ahblm_haddr, 32'h4);
    chk("sr_htrans_t1", bus.ahblm_htrans, 2'b10);
    chk("sr_rdy1_t1",  bus.ahbls_hready_resp[1], 1'b0);
    chk("sr_rdy0_t1",  bus.ahbls_hready_resp[0], 1'b1);
    nxt();
    bus.ahblm_hrdata = 32'hBBBB0004;
    #2;
    chk("sr_rdy1_t2",  bus.ahbls_hready_resp[1], 1'b1);
    chk("sr_rdata1",   bus.ahbls_hrdata[1], 32'hBBBB0004);
    chk("sr_idle_t2",  bus.ahblm_htrans, 2'b00);

    // Downstream stall with held grant
    nxt();
    bus.ahblm_hrdata = 32'h0;
    drive(0, 2'b10, 32'h10, 1'b0, 3'b000);
    #2;
    chk("st_a0_haddr", bus.ahblm_haddr, 32'h10);
    nxt();
    drive(0, 2'b10, 32'h308, 1'b0, 3'b000);
    drive(1, 2'b10, 32'h204, 1'b1, 3'b000);
    bus.ahblm_hready_resp = 1'b0;
    #2;
    chk("st_a1_haddr", bus.ahblm_haddr, 32'h204);
    chk("st_a1_mrdy",  bus.ahblm_hready, 1'b0);
    chk("st_a1_rdy0",  bus.ahbls_hready_resp[0], 1'b0);
    nxt();
    idle(1);
    #2;
    chk("st_a2_haddr", bus.ahblm_haddr, 32'h204);
    chk("st_a2_htrans", bus.ahblm_htrans, 2'b10);
    chk("st_a2_rdy1",  bus.ahbls_hready_resp[1], 1'b0);
    nxt();
    bus.ahblm_hready_resp = 1'b1;
    bus.ahblm_hrdata      = 32'h10101010;
    #2;
    chk("st_a3_haddr", bus.ahblm_haddr, 32'h204);
    chk("st_a3_hwrite", bus.ahblm_hwrite, 1'b1);
    chk("st_a3_rdy0",  bus.ahbls_hready_resp[0], 1'b1);
    chk("st_a3_rdata", bus.ahbls_hrdata[0], 32'h10101010);
    nxt();
    idle(0);
    bus.ahbls_hwdata[1]   = 32'h11112222;
    bus.ahblm_hready_resp = 1'b0;
    #2;
    chk("st_a4_haddr", bus.ahblm_haddr, 32'h308);
    chk("st_a4_hwdata", bus.ahblm_hwdata, 32'h11112222);
    chk("st_a4_rdy",   bus.ahbls_hready_resp, 2'b00);
    nxt();
    #2;
    chk("st_a5_haddr", bus.ahblm_haddr, 32'h308);
    chk("st_a5_htrans", bus.ahblm_htrans, 2'b10);
    chk("st_a5_rdy1",  bus.ahbls_hready_resp[1], 1'b0);
    nxt();
    bus.ahblm_hready_resp = 1'b1;
    #2;
    chk("st_a6_haddr", bus.ahblm_haddr, 32'h308);
    chk("st_a6_rdy",   bus.ahbls_hready_resp, 2'b10);
    nxt();
    bus.ahbls_hwdata[1] = 32'h0;
    bus.ahblm_hrdata    = 32'h30803080;
    #2;
    chk("st_a7_rdy0",  bus.ahbls_hready_resp[0], 1'b1);
    chk("st_a7_rdata", bus.ahbls_hrdata[0], 32'h30803080);
    chk("st_a7_idle",  bus.ahblm_htrans, 2'b00);

    // Error response to port 1
    nxt();
    bus.ahblm_hrdata = 32'h0;
    drive(1, 2'b10, 32'h40, 1'b0, 3'b000);
    #2;
    chk("er_haddr",  bus.ahblm_haddr, 32'h40);
    nxt();
    idle(1);
    bus.ahblm_hresp       = 1'b1;
    bus.ahblm_hready_resp = 1'b0;
    #2;
    chk("er_c1_hresp", bus.ahbls_hresp, 2'b10);
    chk("er_c1_rdy",   bus.ahbls_hready_resp, 2'b01);
    nxt();
    bus.ahblm_hready_resp = 1'b1;
    #2;
    chk("er_c2_hresp", bus.ahbls_hresp, 2'b10);
    chk("er_c2_rdy",   bus.ahbls_hready_resp, 2'b11);
    nxt();
    bus.ahblm_hresp = 1'b0;
    #2;
    chk("er_c3_hresp", bus.ahbls_hresp, 2'b00);

    // INCR4 burst flattened to singles
    for (int k = 0; k < 4; k++) begin
      logic [31:0] a;
      a = 32'(k * 4);
      nxt();
      drive(0, (k == 0) ? 2'b10 : 2'b11, a, 1'b0, 3'b011);
      #2;
      chk("bu_htrans", bus.ahblm_htrans, 2'b10);
      chk("bu_hburst", bus.ahblm_hburst, 3'b000);
      chk("bu_haddr",  bus.ahblm_haddr, a);
      chk("bu_rdy0",   bus.ahbls_hready_resp[0], 1'b1);
    end
    nxt();
    idle(0);

    // Reset while port 1 is buffered
    nxt();
    drive(0, 2'b10, 32'h0, 1'b0, 3'b000);
    drive(1, 2'b10, 32'h4, 1'b0, 3'b000);
    nxt();
    idle(0);
    idle(1);
    bus.ahbls_hwdata[0] = 32'hCAFEF00D;
    #2;
    chk("rb_rdy1",    bus.ahbls_hready_resp[1], 1'b0);
    chk("rb_haddr",   bus.ahblm_haddr, 32'h4);
    chk("rb_hwdata",  bus.ahblm_hwdata, 32'hCAFEF00D);
    rst_n = 1'b0;
    #1;
    chk("rb_htrans",  bus.ahblm_htrans, 2'b00);
    chk("rb_haddr0",  bus.ahblm_haddr, 32'h0);
    chk("rb_hwdata0", bus.ahblm_hwdata, 32'h0);
    chk("rb_rdy",     bus.ahbls_hready_resp, 2'b11);
    chk("rb_hresp",   bus.ahbls_hresp, 2'b00);
    nxt();
    nxt();
    rst_n = 1'b1;
    #2;
    chk("rb_post_htrans", bus.ahblm_htrans, 2'b00);
    chk("rb_post_rdy",    bus.ahbls_hready_resp, 2'b11);
    nxt();
    #2;
    chk("rb_post2_htrans", bus.ahblm_htrans, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
